// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10
    } err_e;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between the core (master) and the data memory (slave).
interface dmem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Word storage with asynchronous read and byte-lane write; word i powers up holding i.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [3:0]       wstrb_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    typedef logic [DEPTH-1:0][31:0] mem_t;

    function automatic mem_t initMem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = 32'(i);
        end
        return m;
    endfunction

    // Contents survive reset, so only a power-up value is given.
    mem_t mem_q = initMem();

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (wstrb_i[k]) begin
                    mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: accepts one request, waits WAIT_CYCLES, accesses, holds the response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);

    localparam int IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int OFF_W = $clog2(WORD_BYTES);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       rdata_q;
    err_e              err_q;

    logic              accept;
    logic              doAccess;
    logic              accWrite;
    logic [ADDR_W-1:0] accAddr;
    logic [31:0]       accWdata;
    logic [3:0]        accWstrb;
    logic [31:0]       memRdata;
    logic              memWe;
    logic [31:0]       rdata_d;
    err_e              err_d;

    assign accept = (state_q == IDLE) && bus.req_valid && rst;

    // With no wait states the access happens on the accept edge, straight from the bus.
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            accWrite = bus.req_write;
            accAddr  = bus.req_addr;
            accWdata = bus.req_wdata;
            accWstrb = bus.req_wstrb;
            doAccess = accept;
        end else begin
            accWrite = write_q;
            accAddr  = addr_q;
            accWdata = wdata_q;
            accWstrb = wstrb_q;
            doAccess = (state_q == BUSY) && (cnt_q == CNT_W'(1)) && rst;
        end
    end

    always_comb begin
        err_d   = ERR_OK;
        rdata_d = '0;
        memWe   = 1'b0;
        if (accAddr[OFF_W-1:0] != '0) begin
            err_d = ERR_MISALIGN;
        end else if (accAddr[ADDR_W-1:OFF_W] >= (ADDR_W-OFF_W)'(DEPTH)) begin
            err_d = ERR_RANGE;
        end else if (accWrite) begin
            memWe = doAccess;
        end else begin
            rdata_d = memRdata;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) uArray (
        .clk     (clk),
        .we_i    (memWe),
        .idx_i   (accAddr[IDX_W+OFF_W-1:OFF_W]),
        .wstrb_i (accWstrb),
        .wdata_i (accWdata),
        .rdata_o (memRdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        wstrb_q <= bus.req_wstrb;
                        cnt_q   <= CNT_W'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            rdata_q <= rdata_d;
                            err_q   <= err_d;
                            state_q <= RESP;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        rdata_q <= rdata_d;
                        err_q   <= err_d;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE) && rst;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: one responder with two wait states, one with none.
module tb_dmem_responder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;

    dmem_if #(.ADDR_W(32)) bus ();
    dmem_if #(.ADDR_W(32)) bus0 ();

    dmem_responder #(
        .DEPTH       (128),
        .WAIT_CYCLES (2),
        .ADDR_W      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dmem_responder #(
        .DEPTH       (128),
        .WAIT_CYCLES (0),
        .ADDR_W      (32)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Runs one full transaction on the two-wait-state responder and returns what came back.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, output logic [31:0] rdata,
                                 output logic [1:0] err, output logic done);
        int n;
        done  = 1'b0;
        rdata = '0;
        err   = '0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.resp_valid) return;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        done  = 1'b1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_handshake ready=%b valid=%b required 0 0", bus.req_ready, bus.resp_valid);
        end
        checks++;
        if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_resp rdata=%h err=%b required 00000000 00", bus.resp_rdata, bus.resp_err);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_ready got=%b required 1", bus.req_ready);
        end
    endtask

    task automatic test_read_latency();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h10;
        @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_accept ready=%b valid=%b required 0 0", bus.req_ready, bus.resp_valid);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_early got=%b required 0", bus.resp_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h4 || bus.resp_err !== 2'b00) begin
            failures++;
            $display("[TB] FAIL latency_resp valid=%b rdata=%h err=%b required 1 00000004 00",
                     bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_store_bytes();
        logic [31:0] rd;
        logic [1:0]  er;
        logic        ok;
        applyStimulus(1'b1, 32'h20, 32'hDEADBEEF, 4'b0011, rd, er, ok);
        checks++;
        if (!ok || rd !== 32'h0 || er !== 2'b00) begin
            failures++;
            $display("[TB] FAIL store_resp done=%b rdata=%h err=%b required 1 00000000 00", ok, rd, er);
        end
        applyStimulus(1'b0, 32'h20, 32'h0, 4'b0000, rd, er, ok);
        checks++;
        if (!ok || rd !== 32'h0000BEEF || er !== 2'b00) begin
            failures++;
            $display("[TB] FAIL store_readback done=%b rdata=%h err=%b required 1 0000beef 00", ok, rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic [1:0]  er;
        logic        ok;
        applyStimulus(1'b0, 32'h22, 32'h0, 4'b0000, rd, er, ok);
        checks++;
        if (!ok || rd !== 32'h0 || er !== 2'b01) begin
            failures++;
            $display("[TB] FAIL misaligned done=%b rdata=%h err=%b required 1 00000000 01", ok, rd, er);
        end
        applyStimulus(1'b1, 32'h200, 32'hDEADBEEF, 4'b1111, rd, er, ok);
        checks++;
        if (!ok || rd !== 32'h0 || er !== 2'b10) begin
            failures++;
            $display("[TB] FAIL out_of_range done=%b rdata=%h err=%b required 1 00000000 10", ok, rd, er);
        end
        applyStimulus(1'b0, 32'h201, 32'h0, 4'b0000, rd, er, ok);
        checks++;
        if (!ok || er !== 2'b01) begin
            failures++;
            $display("[TB] FAIL err_priority done=%b err=%b required 1 01", ok, er);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 4'b0000, rd, er, ok);
        checks++;
        if (!ok || rd !== 32'h0 || er !== 2'b00) begin
            failures++;
            $display("[TB] FAIL word0_intact done=%b rdata=%h err=%b required 1 00000000 00", ok, rd, er);
        end
        applyStimulus(1'b0, 32'h1FC, 32'h0, 4'b0000, rd, er, ok);
        checks++;
        if (!ok || rd !== 32'h7F || er !== 2'b00) begin
            failures++;
            $display("[TB] FAIL last_word done=%b rdata=%h err=%b required 1 0000007f 00", ok, rd, er);
        end
        applyStimulus(1'b1, 32'h24, 32'h12345678, 4'b0000, rd, er, ok);
        applyStimulus(1'b0, 32'h24, 32'h0, 4'b0000, rd, er, ok);
        checks++;
        if (!ok || rd !== 32'h9 || er !== 2'b00) begin
            failures++;
            $display("[TB] FAIL zero_strobe done=%b rdata=%h err=%b required 1 00000009 00", ok, rd, er);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h04;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_addr = 32'h08;
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h1 || bus.resp_err !== 2'b00 ||
                bus.req_ready !== 1'b0) begin
                bad++;
            end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL hold_stable bad_cycles=%0d required 0 (last valid=%b rdata=%h ready=%b)",
                     bad, bus.resp_valid, bus.resp_rdata, bus.req_ready);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_handshake ready=%b valid=%b required 1 0", bus.req_ready, bus.resp_valid);
        end
        @(negedge clk);
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL held_req_accept ready=%b required 0", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h2) begin
            failures++;
            $display("[TB] FAIL held_req_data valid=%b rdata=%h required 1 00000002", bus.resp_valid, bus.resp_rdata);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset_busy();
        logic [31:0] rd;
        logic [1:0]  er;
        logic        ok;
        int          n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h30;
        bus.req_wdata = 32'hFFFFFFFF;
        bus.req_wstrb = 4'b1111;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 2'b00 || bus.resp_valid !== 1'b0 ||
            bus.req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset rdata=%h err=%b valid=%b ready=%b required 00000000 00 0 0",
                     bus.resp_rdata, bus.resp_err, bus.resp_valid, bus.req_ready);
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h30, 32'h0, 4'b0000, rd, er, ok);
        checks++;
        if (!ok || rd !== 32'h0000000C || er !== 2'b00) begin
            failures++;
            $display("[TB] FAIL store_discarded done=%b rdata=%h err=%b required 1 0000000c 00", ok, rd, er);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int lastAccept;
        @(negedge clk);
        bus0.resp_ready = 1'b1;
        bus0.req_write  = 1'b0;
        bus0.req_valid  = 1'b1;
        bus0.req_addr   = 32'h0;
        lastAccept = 0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!bus0.req_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1;
            if (i > 0) begin
                checks++;
                if (cyc - lastAccept != 2) begin
                    failures++;
                    $display("[TB] FAIL b2b_spacing txn=%0d gap=%0d required 2", i, cyc - lastAccept);
                end
            end
            lastAccept = cyc;
            @(negedge clk);
            checks++;
            if (bus0.resp_valid !== 1'b1 || bus0.resp_rdata !== 32'(i) || bus0.resp_err !== 2'b00) begin
                failures++;
                $display("[TB] FAIL b2b_data txn=%0d valid=%b rdata=%h err=%b required 1 %h 00",
                         i, bus0.resp_valid, bus0.resp_rdata, bus0.resp_err, 32'(i));
            end
            if (i == 3) bus0.req_valid = 1'b0;
            else bus0.req_addr = 32'(4 * (i + 1));
        end
        @(negedge clk);
        bus0.resp_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst      = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.req_wstrb   = '0;
        bus.resp_ready  = 1'b0;
        bus0.req_valid  = 1'b0;
        bus0.req_write  = 1'b0;
        bus0.req_addr   = '0;
        bus0.req_wdata  = '0;
        bus0.req_wstrb  = '0;
        bus0.resp_ready = 1'b0;

        test_reset();
        test_read_latency();
        test_store_bytes();
        test_errors();
        test_backpressure();
        test_reset_busy();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
